list_reader: RTL and testbench
==============================

# list_reader

Read-only walker for the card linked lists held in the shared 1024×32 card RAM. Given a head address, it follows `next` pointers and streams each card's suit and value out over a valid/ready handshake, counting cards as it goes. It is the consumer-side counterpart of the store/add/remove/split blocks. Typical uses are hand display, scoring and deck dumps. It never writes RAM.

## Interface
Parameters:
- `MAX_CARDS`, default 52: walk limit; guards against corrupted or cyclic lists. Range 1..63.

Ports:
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a walk; sampled only in IDLE.
- `address`  in  10  head address of the list; 0 means an empty list.
- `card_out`  out  6  {suit[1:0], value[3:0]} of the current card.
- `card_valid`  out  1  `card_out` is valid.
- `card_ready`  in  1  consumer accepts `card_out`.
- `card_count`  out  6  cards accepted so far in this walk; holds its final value after done.
- `finished_reading`  out  1  high while IDLE (block free).
- `done`  out  1  one-cycle pulse when a walk ends.
- `error`  out  1  set at walk end if the list was bad; cleared on next start.
- `ram_address`  out  10  RAM read address (registered).
- `ram_clock`  out  1  equals `clock`.
- `ram_data`  out  32  constant 0.
- `ram_wren`  out  1  constant 0.
- `ram_q`  in  32  RAM read data.

## Operation
- Card word format: bit31 = in-use flag; bits 21:20 = suit; bits 19:16 = value; bits 9:0 = next address (0 = end of list); other bits ignored.
- State IDLE:
  - `finished_reading`=1, `card_valid`=0.
  - On `start`, clear `card_count` and `error`.
  - If `address`==0: go to DONE.
  - Else: `ram_address`<=`address`, go to WAIT.
- State WAIT: one cycle for the RAM read latency, then go to CHECK.
- State CHECK (samples `ram_q`):
  - If bit31==0: `error`<=1, go to DONE.
  - Else: `card_out`<=`ram_q[21:16]`, latch next<=`ram_q[9:0]`, `card_valid`<=1, go to OUTPUT.
- State OUTPUT: hold `card_out` and `card_valid` until `card_ready`. On a cycle with `card_valid`&`card_ready`:
  - `card_valid`<=0 and `card_count`<=`card_count`+1.
  - If next==0: go to DONE.
  - Else if `card_count`+1==`MAX_CARDS`: `error`<=1, go to DONE.
  - Else `ram_address`<=next, go to WAIT.
- State DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. `address` is latched only in IDLE.
- `card_count` is a 6-bit counter. With `MAX_CARDS`≤63 it cannot wrap.
- Reset values:
  - state IDLE.
  - `card_valid`=0, `done`=0, `error`=0.
  - `card_count`=0, `card_out`=0, `ram_address`=0.
  - `finished_reading`=1.
- Reset asserted mid-walk aborts on the next edge. No `done` pulse is produced. `card_valid` drops.

## Timing
- RAM model: address is registered by the RAM on edge N; `ram_q` is valid for sampling on edge N+1. The WAIT state covers this.
- `start` sampled at edge E0 → `card_valid` high after E2 (2-cycle latency).
- With `card_ready` held high: one card per 3 cycles (OUTPUT, WAIT, CHECK). `card_valid` is low during WAIT and CHECK.
- `card_valid` never drops without a handshake, except on reset.
- `card_out` is stable while `card_valid`=1.
- Last-card handshake at edge Ek → `done` high during Ek..Ek+1 → IDLE (`finished_reading`=1) after Ek+1.
- Empty list: start edge E0 → `done` after E0 → IDLE after E1. `card_count`=0.
- Corrupt word: `done` and `error` are asserted the cycle after CHECK. No card is emitted for that word.
- `card_ready` may be high before `card_valid`; it has no effect outside OUTPUT.

## Test plan
- **Three-card list:**
  - Stimulus: RAM[5]={1,suit 2,value 12,next 9}, RAM[9]={1,0,1,next 3}, RAM[3]={1,3,13,next 0}; start with address=5; ready=1.
  - Required: `card_out` sequence 0x2C, 0x01, 0x3D, spaced 3 cycles apart; then `done` pulse, `card_count`=3, `error`=0.
- **Empty list:**
  - Stimulus: address=0, start.
  - Required: `done` one cycle after start, `card_count`=0, `card_valid` never high, no RAM address change.
- **Backpressure:**
  - Stimulus: same three-card list, `card_ready` low for 7 cycles on the second card.
  - Required: `card_out`=0x01 stable and `card_valid` high throughout; `card_count` stays 1 until the handshake.
- **Corrupt/cyclic list:**
  - Stimulus A: RAM[9] bit31=0 on the three-card list.
  - Required A: first card emitted, then `error`=1, `done`, `card_count`=1.
  - Stimulus B: RAM[7]={1,0,4,next 7} with `MAX_CARDS`=52.
  - Required B: exactly 52 cards of 0x04, then `error`=1, `done`.
- **Reset and start-while-busy:**
  - Stimulus: reset asserted while in OUTPUT.
  - Required: next cycle `card_valid`=0, `finished_reading`=1, `card_count`=0, no `done` pulse.
  - Stimulus: `start` pulsed during a walk.
  - Required: ignored.
- **Write safety:**
  - Required: across all scenarios `ram_wren`=0 and `ram_data`=0 on every cycle.

Source files
------------

// File: rtl/list_reader.sv
// Walks a linked list of card words in the shared card RAM, streaming each
// card's {suit, value} over a valid/ready handshake. Read-only: never writes RAM.
module list_reader #(
    parameter int MAX_CARDS = 52
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  address,
    output logic [5:0]  card_out,
    output logic        card_valid,
    input  logic        card_ready,
    output logic [5:0]  card_count,
    output logic        finished_reading,
    output logic        done,
    output logic        error,
    output logic [9:0]  ram_address,
    output logic        ram_clock,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CHECK,
        OUTPUT,
        DONE
    } state_t;

    localparam logic [5:0] MAX_COUNT = 6'(MAX_CARDS);

    state_t      state_reg, state_next;
    logic [5:0]  card_out_reg, card_out_next;
    logic        card_valid_reg, card_valid_next;
    logic [5:0]  card_count_reg, card_count_next;
    logic        error_reg, error_next;
    logic [9:0]  ram_address_reg, ram_address_next;
    logic [9:0]  link_reg, link_next;
    logic [5:0]  count_inc;

    // Only the in-use flag, suit/value and next-pointer fields matter.
    logic unused_ram_bits;
    assign unused_ram_bits = ^{ram_q[30:22], ram_q[15:10]};

    assign count_inc = card_count_reg + 6'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            card_out_reg    <= '0;
            card_valid_reg  <= 1'b0;
            card_count_reg  <= '0;
            error_reg       <= 1'b0;
            ram_address_reg <= '0;
            link_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            card_out_reg    <= card_out_next;
            card_valid_reg  <= card_valid_next;
            card_count_reg  <= card_count_next;
            error_reg       <= error_next;
            ram_address_reg <= ram_address_next;
            link_reg        <= link_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        card_out_next    = card_out_reg;
        card_valid_next  = card_valid_reg;
        card_count_next  = card_count_reg;
        error_next       = error_reg;
        ram_address_next = ram_address_reg;
        link_next        = link_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    card_count_next = '0;
                    error_next      = 1'b0;
                    if (address == 10'd0) begin
                        state_next = DONE;
                    end else begin
                        ram_address_next = address;
                        state_next       = WAIT;
                    end
                end
            end
            WAIT: state_next = CHECK;
            CHECK: begin
                if (!ram_q[31]) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end else begin
                    card_out_next   = ram_q[21:16];
                    link_next       = ram_q[9:0];
                    card_valid_next = 1'b1;
                    state_next      = OUTPUT;
                end
            end
            OUTPUT: begin
                if (card_valid_reg && card_ready) begin
                    card_valid_next = 1'b0;
                    card_count_next = count_inc;
                    // End of list wins over the walk limit on the same card.
                    if (link_reg == 10'd0) begin
                        state_next = DONE;
                    end else if (count_inc == MAX_COUNT) begin
                        error_next = 1'b1;
                        state_next = DONE;
                    end else begin
                        ram_address_next = link_reg;
                        state_next       = WAIT;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign card_out         = card_out_reg;
    assign card_valid       = card_valid_reg;
    assign card_count       = card_count_reg;
    assign error            = error_reg;
    assign ram_address      = ram_address_reg;
    assign done             = (state_reg == DONE);
    assign finished_reading = (state_reg == IDLE);
    assign ram_clock        = clock;
    assign ram_data         = 32'd0;
    assign ram_wren         = 1'b0;

endmodule

// File: tb/tb_list_reader.sv
// Directed bench for list_reader: walks hand-built lists in a behavioural
// 1024x32 RAM with one-cycle registered read and checks streams and timing.
module tb_list_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  address;
    logic [5:0]  card_out;
    logic        card_valid;
    logic        card_ready;
    logic [5:0]  card_count;
    logic        finished_reading;
    logic        done;
    logic        error;
    logic [9:0]  ram_address;
    logic        ram_clock;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    logic [31:0] mem [1024];

    int errors = 0;
    int checks = 0;

    logic [5:0] got_cards[$];
    int         got_cycles[$];
    int         done_cycle;
    logic [5:0] end_count;
    logic       end_error;
    int         hold_left;

    list_reader #(.MAX_CARDS(52)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .address          (address),
        .card_out         (card_out),
        .card_valid       (card_valid),
        .card_ready       (card_ready),
        .card_count       (card_count),
        .finished_reading (finished_reading),
        .done             (done),
        .error            (error),
        .ram_address      (ram_address),
        .ram_clock        (ram_clock),
        .ram_data         (ram_data),
        .ram_wren         (ram_wren),
        .ram_q            (ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ram_q <= mem[ram_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The block must never write RAM, on any cycle.
    always @(negedge clock) begin
        check("ram_wren", {31'd0, ram_wren}, 32'd0);
        check("ram_data", ram_data, 32'd0);
    end

    // Pulse start at cycle 0; cycle n is the negedge after the n-th rising edge.
    task automatic run_walk(input logic [9:0] addr, input int hold_card, input int hold_len,
                            input logic [5:0] hold_exp, input int busy_cycle, input int budget);
        got_cards.delete();
        got_cycles.delete();
        done_cycle = -1;
        end_count  = 'x;
        end_error  = 'x;
        hold_left  = hold_len;
        @(negedge clock);
        start      = 1'b1;
        address    = addr;
        card_ready = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clock);
            start   = (cyc == busy_cycle);
            address = (cyc == busy_cycle) ? 10'd0 : 10'h2AA;
            if (done) begin
                done_cycle = cyc;
                end_count  = card_count;
                end_error  = error;
                break;
            end
            if (card_valid && got_cards.size() == hold_card - 1 && hold_left > 0) begin
                card_ready = 1'b0;
                hold_left--;
                check("hold_card", {26'd0, card_out}, {26'd0, hold_exp});
                check("hold_count", {26'd0, card_count}, 32'(hold_card - 1));
            end else begin
                card_ready = 1'b1;
                if (card_valid) begin
                    got_cards.push_back(card_out);
                    got_cycles.push_back(cyc);
                end
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, done_cycle >= 0}, 32'd1);
        check("hold_used", 32'(hold_left), 32'd0);
        @(negedge clock);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_after", {31'd0, finished_reading}, 32'd1);
    endtask

    task automatic check_three(input string tag, input int first_cycle, input int exp_done);
        logic [5:0] exp3 [3];
        exp3 = '{6'h2C, 6'h01, 6'h3D};
        check({tag, "_n"}, 32'(got_cards.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_card"}, (i < got_cards.size()) ? {26'd0, got_cards[i]} : 32'hFFFF_FFFF,
                  {26'd0, exp3[i]});
            if (i == 0)
                check({tag, "_c0"}, (i < got_cycles.size()) ? 32'(got_cycles[i]) : 32'hFFFF_FFFF,
                      32'(first_cycle));
        end
        check({tag, "_done"}, 32'(done_cycle), 32'(exp_done));
        check({tag, "_count"}, {26'd0, end_count}, 32'd3);
        check({tag, "_err"}, {31'd0, end_error}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[5] = 32'h802C_0009;
        mem[9] = 32'h8001_0003;
        mem[3] = 32'h843D_F400;   // junk in ignored bits
        mem[7] = 32'h8004_0007;   // self-loop
        reset      = 1'b1;
        start      = 1'b0;
        address    = 10'd0;
        card_ready = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_valid", {31'd0, card_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_count", {26'd0, card_count}, 32'd0);
        check("rst_card", {26'd0, card_out}, 32'd0);
        check("rst_addr", {22'd0, ram_address}, 32'd0);
        check("rst_idle", {31'd0, finished_reading}, 32'd1);
        reset = 1'b0;

        // Empty list: done at cycle 1, nothing emitted, address untouched
        run_walk(10'd0, 0, 0, 6'h00, 0, 20);
        check("empty_done", 32'(done_cycle), 32'd1);
        check("empty_n", 32'(got_cards.size()), 32'd0);
        check("empty_count", {26'd0, end_count}, 32'd0);
        check("empty_addr", {22'd0, ram_address}, 32'd0);

        // Three-card list, one card every 3 cycles
        run_walk(10'd5, 0, 0, 6'h00, 0, 40);
        check_three("three", 3, 10);
        for (int i = 1; i < 3; i++)
            check("three_gap", (i < got_cycles.size()) ? 32'(got_cycles[i] - got_cycles[i-1]) : 32'hFFFF_FFFF,
                  32'd3);
        check("three_addr", {22'd0, ram_address}, 32'd3);

        // Backpressure: 7 stalled cycles on the second card
        run_walk(10'd5, 2, 7, 6'h01, 0, 60);
        check_three("bp", 3, 17);

        // start pulsed mid-walk (address 0) is ignored
        run_walk(10'd5, 0, 0, 6'h00, 4, 40);
        check_three("busy", 3, 10);

        // Corrupt second word
        mem[9] = 32'h0001_0003;
        run_walk(10'd5, 0, 0, 6'h00, 0, 40);
        check("bad_n", 32'(got_cards.size()), 32'd1);
        check("bad_card", (got_cards.size() > 0) ? {26'd0, got_cards[0]} : 32'hFFFF_FFFF, 32'h2C);
        check("bad_done", 32'(done_cycle), 32'd6);
        check("bad_count", {26'd0, end_count}, 32'd1);
        check("bad_err", {31'd0, end_error}, 32'd1);
        mem[9] = 32'h8001_0003;

        // Cyclic list hits the 52-card limit
        run_walk(10'd7, 0, 0, 6'h00, 0, 400);
        check("cyc_n", 32'(got_cards.size()), 32'd52);
        for (int i = 0; i < got_cards.size(); i++)
            check("cyc_card", {26'd0, got_cards[i]}, 32'h04);
        check("cyc_done", 32'(done_cycle), 32'd157);
        check("cyc_count", {26'd0, end_count}, 32'd52);
        check("cyc_err", {31'd0, end_error}, 32'd1);

        // Error clears on the next start
        run_walk(10'd5, 0, 0, 6'h00, 0, 40);
        check_three("clr", 3, 10);

        // Reset while a card waits in OUTPUT
        @(negedge clock);
        start      = 1'b1;
        address    = 10'd5;
        card_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("pre_rst_valid", {31'd0, card_valid}, 32'd1);
        check("pre_rst_count", {26'd0, card_count}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_valid", {31'd0, card_valid}, 32'd0);
        check("mid_rst_idle", {31'd0, finished_reading}, 32'd1);
        check("mid_rst_count", {26'd0, card_count}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        card_ready = 1'b1;
        repeat (3) @(negedge clock) begin
            check("post_rst_done", {31'd0, done}, 32'd0);
            check("post_rst_valid", {31'd0, card_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
